// File: rtl/morse_pkg.sv
// morse_pkg: shared Morse constants, receiver state type and letter table
package morse_pkg;
  localparam logic DOT = 1'b0;
  localparam logic DASH = 1'b1;
  localparam int MORSE_DASH_MIN = 2;
  localparam int MORSE_DASH_MAX = 4;
  localparam int MORSE_LETTER_GAP = 3;
  localparam int MORSE_WORD_GAP = 7;
  localparam int MORSE_MAX_LEN = 4;
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_MARK,
    RX_SPACE,
    RX_GAP,
    RX_RECOVER
  } morse_rx_state_t;
  typedef struct packed {
    logic [3:0] code;
    logic [2:0] len;
    logic [7:0] ascii;
  } morse_letter_t;
  // first element sits at bit len-1, last element at bit 0
  localparam morse_letter_t MORSE_TABLE [26] = '{
    '{4'b0001, 3'd2, "a"}, '{4'b1000, 3'd4, "b"}, '{4'b1010, 3'd4, "c"},
    '{4'b0100, 3'd3, "d"}, '{4'b0000, 3'd1, "e"}, '{4'b0010, 3'd4, "f"},
    '{4'b0110, 3'd3, "g"}, '{4'b0000, 3'd4, "h"}, '{4'b0000, 3'd2, "i"},
    '{4'b0111, 3'd4, "j"}, '{4'b0101, 3'd3, "k"}, '{4'b0100, 3'd4, "l"},
    '{4'b0011, 3'd2, "m"}, '{4'b0010, 3'd2, "n"}, '{4'b0111, 3'd3, "o"},
    '{4'b0110, 3'd4, "p"}, '{4'b1101, 3'd4, "q"}, '{4'b0010, 3'd3, "r"},
    '{4'b0000, 3'd3, "s"}, '{4'b0001, 3'd1, "t"}, '{4'b0001, 3'd3, "u"},
    '{4'b0001, 3'd4, "v"}, '{4'b0011, 3'd3, "w"}, '{4'b1001, 3'd4, "x"},
    '{4'b1011, 3'd4, "y"}, '{4'b1100, 3'd4, "z"}
  };
endpackage

// File: rtl/morse_lut.sv
// morse_lut: element pattern to lowercase ASCII lookup
module morse_lut
  import morse_pkg::*;
(
  input  logic [3:0] code,
  input  logic [2:0] len,
  output logic [7:0] ascii,
  output logic       hit
);
  // a miss reports "?" so the caller can emit it directly
  always_comb begin
    ascii = 8'h3F;
    hit = 1'b0;
    for (int i = 0; i < 26; i++)
      if (code == MORSE_TABLE[i].code && len == MORSE_TABLE[i].len) begin
        ascii = MORSE_TABLE[i].ascii;
        hit = 1'b1;
      end
  end
endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: unit-sampled Morse receiver emitting one ASCII char per letter and a space per word gap
module morse_decoder
  import morse_pkg::*;
#(
  parameter int DASH_MIN = MORSE_DASH_MIN,
  parameter int DASH_MAX = MORSE_DASH_MAX,
  parameter int LETTER_GAP = MORSE_LETTER_GAP,
  parameter int WORD_GAP = MORSE_WORD_GAP
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       tick,
  input  logic       din,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       err
);
  localparam int RMAX = DASH_MAX > WORD_GAP ? DASH_MAX : WORD_GAP;
  localparam int RW = $clog2(RMAX + 1);
  morse_rx_state_t state, state_n;
  logic [RW-1:0] run, run_n;
  logic [3:0] code, code_n;
  logic [2:0] len, len_n;
  logic [7:0] char_n, lut_ascii;
  logic valid_n, err_n, lut_hit, elem;
  morse_lut u_lut (
    .code(code),
    .len(len),
    .ascii(lut_ascii),
    .hit(lut_hit)
  );
  assign elem = run < RW'(DASH_MIN) ? DOT : DASH;
  // run comparisons use the pre-increment value so run never exceeds its maximum
  always_comb begin
    state_n = state;
    run_n = run;
    code_n = code;
    len_n = len;
    char_n = char_out;
    valid_n = 1'b0;
    err_n = 1'b0;
    if (tick)
      case (state)
        RX_IDLE: begin
          state_n = din ? RX_MARK : RX_IDLE;
          run_n = din ? RW'(1) : '0;
        end
        RX_MARK:
          if (din) begin
            err_n = run == RW'(DASH_MAX);
            state_n = err_n ? RX_RECOVER : RX_MARK;
            run_n = err_n ? '0 : run + RW'(1);
            code_n = err_n ? 4'd0 : code;
            len_n = err_n ? 3'd0 : len;
          end else begin
            err_n = len == 3'(MORSE_MAX_LEN);
            state_n = err_n ? RX_RECOVER : RX_SPACE;
            run_n = RW'(1);
            code_n = err_n ? 4'd0 : {code[2:0], elem};
            len_n = err_n ? 3'd0 : len + 3'd1;
          end
        RX_SPACE:
          if (din) begin
            state_n = RX_MARK;
            run_n = RW'(1);
          end else begin
            valid_n = run == RW'(LETTER_GAP - 1);
            err_n = valid_n && !lut_hit;
            char_n = valid_n ? lut_ascii : char_out;
            state_n = valid_n ? RX_GAP : RX_SPACE;
            run_n = run + RW'(1);
            code_n = valid_n ? 4'd0 : code;
            len_n = valid_n ? 3'd0 : len;
          end
        RX_GAP:
          if (din) begin
            state_n = RX_MARK;
            run_n = RW'(1);
          end else begin
            valid_n = run == RW'(WORD_GAP - 1);
            char_n = valid_n ? 8'h20 : char_out;
            state_n = valid_n ? RX_IDLE : RX_GAP;
            run_n = valid_n ? '0 : run + RW'(1);
          end
        RX_RECOVER: begin
          state_n = !din && run == RW'(LETTER_GAP - 1) ? RX_IDLE : RX_RECOVER;
          run_n = din || state_n == RX_IDLE ? '0 : run + RW'(1);
          code_n = 4'd0;
          len_n = 3'd0;
        end
        default: begin
          state_n = RX_IDLE;
          run_n = '0;
          code_n = 4'd0;
          len_n = 3'd0;
        end
      endcase
  end
  // state and registered output strobes
  always_ff @(posedge clkin) begin
    if (rst) begin
      state <= RX_IDLE;
      run <= '0;
      code <= 4'd0;
      len <= 3'd0;
      char_out <= 8'h00;
      char_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      run <= run_n;
      code <= code_n;
      len <= len_n;
      char_out <= char_n;
      char_valid <= valid_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: scoreboard bench against a run-length Morse reference model
module tb_morse_decoder;
  localparam int DMIN = 2;
  localparam int DMAX = 4;
  localparam int LG = 3;
  localparam int WG = 7;
  logic clkin = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic din = 1'b0;
  logic [7:0] char_out;
  logic char_valid, err;
  morse_decoder #(.DASH_MIN(DMIN), .DASH_MAX(DMAX), .LETTER_GAP(LG), .WORD_GAP(WG)) dut (
    .clkin(clkin),
    .rst(rst),
    .tick(tick),
    .din(din),
    .char_out(char_out),
    .char_valid(char_valid),
    .err(err)
  );
  always #5 clkin = ~clkin;
  typedef struct {
    int cyc;
    bit v;
    logic [7:0] ch;
    bit e;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit gaps = 0;
  string morse [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                        "..-", "...-", ".--", "-..-", "-.--", "--.."};
  int mark = 0;
  int zeros = 0;
  string pat = "";
  bit wpend = 0;
  bit bad = 0;
  always @(posedge clkin) cyc <= cyc + 1;
  function automatic void push(bit v, logic [7:0] ch, bit e);
    exp_t x;
    x.cyc = cyc + 1;
    x.v = v;
    x.ch = ch;
    x.e = e;
    q.push_back(x);
  endfunction
  function automatic void model_reset();
    mark = 0;
    zeros = 0;
    pat = "";
    wpend = 0;
    bad = 0;
  endfunction
  function automatic void fail_to_recover(int z);
    push(0, 8'h00, 1);
    bad = 1;
    zeros = z;
    pat = "";
    mark = 0;
    wpend = 0;
  endfunction
  function automatic void model(bit d);
    int hit;
    if (bad) begin
      zeros = d ? 0 : zeros + 1;
      if (zeros == LG) begin
        bad = 0;
        zeros = 0;
      end
    end else if (d) begin
      if (mark == 0) begin
        wpend = 0;
        zeros = 0;
      end
      mark++;
      if (mark > DMAX) fail_to_recover(0);
    end else if (mark > 0) begin
      if (pat.len() == 4) fail_to_recover(1);
      else begin
        pat = {pat, mark < DMIN ? "." : "-"};
        mark = 0;
        zeros = 1;
      end
    end else if (pat.len() > 0) begin
      zeros++;
      if (zeros == LG) begin
        hit = -1;
        foreach (morse[i]) if (morse[i] == pat) hit = i;
        if (hit >= 0) push(1, 8'(97 + hit), 0);
        else push(1, 8'h3F, 1);
        pat = "";
        wpend = 1;
      end
    end else if (wpend) begin
      zeros++;
      if (zeros == WG) begin
        push(1, 8'h20, 0);
        wpend = 0;
      end
    end
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      din = 1'($urandom);
      @(posedge clkin);
      #1;
    end
  endtask
  task automatic tk(input bit d);
    tick = 1'b1;
    din = d;
    model(d);
    @(posedge clkin);
    #1;
    tick = 1'b0;
    din = 1'($urandom);
    if (gaps) idle($urandom_range(0, 2));
  endtask
  task automatic bits(input string s);
    foreach (s[i]) tk(s[i] == "1");
  endtask
  task automatic mreset();
    rst = 1'b1;
    tick = 1'b1;
    din = 1'b1;
    @(posedge clkin);
    #1;
    tick = 1'b0;
    @(posedge clkin);
    #1;
    rst = 1'b0;
    model_reset();
  endtask
  // scoreboard monitor: every strobe must match the head of the expectation queue in time and value
  always @(negedge clkin) begin
    exp_t x;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      x = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_strobe cyc=%0d expected v=%0b ch=%h err=%0b", x.cyc, x.v, x.ch, x.e);
    end
    if (char_valid === 1'b1 || err === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe cyc=%0d v=%0b ch=%h err=%0b", cyc, char_valid, char_out, err);
      end else begin
        x = q.pop_front();
        if (x.cyc != cyc || char_valid !== x.v || err !== x.e || (x.v && char_out !== x.ch)) begin
          failures++;
          $display("FAIL strobe cyc=%0d got v=%0b ch=%h err=%0b, expected cyc=%0d v=%0b ch=%h err=%0b",
                   cyc, char_valid, char_out, err, x.cyc, x.v, x.ch, x.e);
        end
      end
    end
  end
  initial begin
    int m, s;
    @(posedge clkin);
    @(negedge clkin);
    checks += 3;
    if (char_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_char_out got=%h expected=00", char_out);
    end
    if (char_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_char_valid got=%b expected=0", char_valid);
    end
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b expected=0", err);
    end
    @(posedge clkin);
    #1;
    rst = 1'b0;
    model_reset();
    bits("10111000");
    bits("0000");
    bits("10000000");
    bits("0000");
    bits("11111");
    bits("000");
    bits("1110000000");
    bits("1010101010");
    bits("0000000");
    bits("10111010111000");
    bits("0000");
    bits("101");
    mreset();
    bits("10000000");
    idle(20);
    bits("1000");
    bits("0000");
    bits("11110000000");
    gaps = 1;
    repeat (150) begin
      m = $urandom_range(1, 6);
      s = $urandom_range(1, 9);
      repeat (m) tk(1'b1);
      repeat (s) tk(1'b0);
      if ($urandom_range(0, 40) == 0) mreset();
    end
    gaps = 0;
    bits("0000000000");
    idle(5);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations got=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/morse_decoder.md
# morse_decoder

Serial Morse receiver that sits directly downstream of the Morse code generator. It samples the generator's on/off keyed bit stream once per Morse unit and classifies mark and space run lengths into dots, dashes, letter gaps and word gaps. It looks up the accumulated element pattern and emits one lowercase ASCII character per letter, plus a single space per word gap, as a one-cycle valid pulse for a downstream character sink or loopback checker.

## Interface
- `DASH_MIN`, default 2: shortest mark, in units, classified as a dash. Shorter marks are dots.
- `DASH_MAX`, default 4: longest legal mark, in units. Longer marks are errors.
- `LETTER_GAP`, default 3: space length, in units, that ends a letter.
- `WORD_GAP`, default 7: space length, in units, that ends a word.
- `clkin` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `tick` in 1: unit strobe. A one-`clkin` pulse once per Morse unit.
- `din` in 1: keyed Morse stream. 1 = mark. Sampled only when `tick`=1.
- `char_out` out 8: decoded ASCII character.
- `char_valid` out 1: one-cycle strobe qualifying `char_out`.
- `err` out 1: one-cycle strobe for a malformed symbol.

## Operation
- **State machine:** IDLE, MARK, SPACE, GAP, RECOVER. State changes only on cycles with `tick`=1.
- **Element encoding:** dot = 0, dash = 1. Elements are shifted into `code[3:0]` LSB-first, so the first element ends at the MSB of the final `len`-bit pattern. `len[2:0]` counts elements.
- **IDLE:**
  - `din`=1 → MARK with `run`=1.
  - `din`=0 → stay in IDLE. No output.
- **MARK:**
  - `din`=1 → `run`+1. If `run` would exceed `DASH_MAX`: pulse `err` and go to RECOVER.
  - `din`=0 → classify the mark (`run` < `DASH_MIN` is a dot, otherwise a dash) and append it. If this would be the 5th element: pulse `err` and go to RECOVER. Otherwise go to SPACE with `run`=1.
- **SPACE:**
  - `din`=1 → MARK with `run`=1. The gap was intra-letter.
  - `din`=0 → `run`+1. When `run` reaches `LETTER_GAP`: look up (`code`, `len`), emit, clear `code`/`len`, go to GAP.
- **Lookup:**
  - Hit: `char_out` = "a".."z".
  - Miss: `char_out` = 8'h3F ("?") and `err`=1, both in the same cycle as `char_valid`.
- **GAP:**
  - `din`=0 → `run`+1, saturating at `WORD_GAP`. When `run` reaches `WORD_GAP`: emit 8'h20 exactly once, then go to IDLE.
  - `din`=1 → MARK with `run`=1. No space is emitted.
- **RECOVER:**
  - Discard `code`/`len`. No character is emitted.
  - Count `din`=0 units. A `din`=1 restarts the count at 0.
  - When the count reaches `LETTER_GAP` → IDLE.
- **Reset values:** `char_out`=8'h00, `char_valid`=0, `err`=0. State is IDLE; `run`, `code` and `len` are all 0.
- **Reset mid-letter:** discards the partial letter and emits nothing.
- **Counter width:** `run` is wide enough for `max(DASH_MAX, WORD_GAP)`. It never wraps.

## Timing
- `char_valid`, `char_out` and `err` are registered. They assert in the `clkin` cycle immediately after the `tick` cycle whose sample reaches the threshold. Latency is 1 `clkin`.
- Strobes are exactly one `clkin` wide regardless of tick spacing.
- `char_out` holds its last value between strobes.
- `tick` on consecutive `clkin` cycles is legal: every-cycle sampling is supported.
- `din` is ignored while `tick`=0.
- `rst` wins over `tick` in the same cycle.
- At most one of {letter emit, space emit} occurs per tick.
- `err` coincides with `char_valid` only on a lookup miss.

## Structure
- **Package `morse_pkg`:**
  - `DOT`/`DASH` constants.
  - State enum `morse_rx_state_t`.
  - Default gap constants.
  - 26-entry letter table (code, len, ASCII) shared with the generator.
- **Sub-module `morse_lut`:** combinational (`code[3:0]`, `len[2:0]`) → (ASCII[7:0], `hit`).
- Top-level RTL target: about 200 lines.

## Test plan
- **Letter "a":** drive 1,0,1,1,1,0,0,0 on successive ticks → `char_valid` one cycle after the 8th tick, `char_out`=8'h61, `err`=0.
- **Word gap:** "e" then 7 zero units → `char_out`=8'h65, followed by 8'h20 one cycle after the 7th zero tick. Further zeros produce nothing.
- **Over-long mark:** 5 consecutive marks → `err` one cycle after the 5th tick, no `char_valid`. After 3 zeros the decoder accepts "t" (1,1,1,0,0,0) → 8'h74.
- **Five elements / unmapped pattern:**
  - Five dots → `err`, no character.
  - ".-.-" (maps to no letter) → `char_valid` with 8'h3F and `err` together.
- **Reset mid-letter:** assert `rst` after "1,0,1" → no strobes. Next "1,0,0,0" decodes to 8'h65.
- **Tick gating:** toggle `din` randomly with `tick`=0 for 20 cycles → no state change and no strobes.
